// File: rtl/hazard_scoreboard_if.sv
// Decoder <-> hazard unit bundle.
//   master : D-stage decoder / E-stage MDU side; drives register fields, Tuse/Tnew and MDU
//            controls; receives stall_D, fwd_rs_D, fwd_rt_D and md_busy.
//   slave  : hazard_scoreboard; the reverse directions.
// FW is the forwarding-select width, clog2(NUM_STAGES+1).
interface hazard_scoreboard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned TW     = 3,
  parameter int unsigned FW     = 2
);
  logic [REG_AW-1:0] rs_D;
  logic [REG_AW-1:0] rt_D;
  logic [TW-1:0]     Tuse_rs;
  logic [TW-1:0]     Tuse_rt;
  logic              we_D;
  logic [REG_AW-1:0] dest_D;
  logic [TW-1:0]     Tnew_D;
  logic              md_use_D;
  logic              md_start;
  logic              md_is_div;
  logic              stall_D;
  logic [FW-1:0]     fwd_rs_D;
  logic [FW-1:0]     fwd_rt_D;
  logic              md_busy;

  modport master (
    output rs_D, rt_D, Tuse_rs, Tuse_rt, we_D, dest_D, Tnew_D, md_use_D, md_start, md_is_div,
    input  stall_D, fwd_rs_D, fwd_rt_D, md_busy
  );

  modport slave (
    input  rs_D, rt_D, Tuse_rs, Tuse_rt, we_D, dest_D, Tnew_D, md_use_D, md_start, md_is_div,
    output stall_D, fwd_rs_D, fwd_rt_D, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit for the pipelined MIPS core.
// A shift-register scoreboard holds one entry per stage after D (1=E .. NUM_STAGES) with the
// destination register and the remaining cycles until its result is forwardable. From it the
// unit derives stall_D and the D-stage forwarding source for rs/rt, and it interlocks HI/LO
// readers against a busy countdown for the mult/div unit.
// Ports:
//   clk   : pipeline clock
//   reset : synchronous, active-high; clears scoreboard and MDU countdown
//   bus   : hazard_scoreboard_if.slave (D-stage fields in, stall/forward/busy out)
module hazard_scoreboard #(
  parameter int unsigned NUM_STAGES    = 3,
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned TW            = 3,
  parameter int unsigned MD_MUL_CYCLES = 5,
  parameter int unsigned MD_DIV_CYCLES = 10,
  parameter int unsigned CW            = 4,
  localparam int unsigned FW           = $clog2(NUM_STAGES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave bus
);

  // Scoreboard state, index k = stage k after D
  logic [NUM_STAGES:1] valid_q, valid_d;
  logic [REG_AW-1:0]   addr_q [1:NUM_STAGES];
  logic [REG_AW-1:0]   addr_d [1:NUM_STAGES];
  logic [TW-1:0]       tnew_q [1:NUM_STAGES];
  logic [TW-1:0]       tnew_d [1:NUM_STAGES];
  logic [CW-1:0]       cnt_q, cnt_d;

  logic          rs_hit, rt_hit;
  logic [FW-1:0] rs_k, rt_k;
  logic [TW-1:0] rs_tnew, rt_tnew;
  logic          md_busy;
  logic          mdu_stall;
  logic          stall;

  // Nearest-match search. Walking from the oldest stage down to stage 1 lets the youngest
  // matching entry overwrite older ones, so older writes to the same register are shadowed.
  always_comb begin
    rs_hit  = 1'b0;
    rs_k    = '0;
    rs_tnew = '0;
    rt_hit  = 1'b0;
    rt_k    = '0;
    rt_tnew = '0;
    for (int k = int'(NUM_STAGES); k >= 1; k--) begin
      if (bus.Tuse_rs != '1 && bus.rs_D != '0 && valid_q[k] && addr_q[k] == bus.rs_D) begin
        rs_hit  = 1'b1;
        rs_k    = FW'(k);
        rs_tnew = tnew_q[k];
      end
      if (bus.Tuse_rt != '1 && bus.rt_D != '0 && valid_q[k] && addr_q[k] == bus.rt_D) begin
        rt_hit  = 1'b1;
        rt_k    = FW'(k);
        rt_tnew = tnew_q[k];
      end
    end
  end

  always_comb begin
    md_busy   = (cnt_q != '0);
    mdu_stall = bus.md_use_D && (bus.md_start || md_busy);
    stall     = (rs_hit && (rs_tnew > bus.Tuse_rs)) ||
                (rt_hit && (rt_tnew > bus.Tuse_rt)) ||
                mdu_stall;
  end

  // Forward selects are driven regardless of stall; the pipeline ignores them while stalled.
  assign bus.stall_D  = stall;
  assign bus.fwd_rs_D = (rs_hit && rs_tnew == '0) ? rs_k : '0;
  assign bus.fwd_rt_D = (rt_hit && rt_tnew == '0) ? rt_k : '0;
  assign bus.md_busy  = md_busy;

  // Shift: stage 1 takes the D instruction (or a bubble on stall); older entries advance with
  // a saturating tnew decrement; the last entry falls off.
  always_comb begin
    valid_d    = '0;
    valid_d[1] = bus.we_D && (bus.dest_D != '0) && !stall;
    addr_d[1]  = bus.dest_D;
    tnew_d[1]  = bus.Tnew_D;
    for (int k = 2; k <= int'(NUM_STAGES); k++) begin
      valid_d[k] = valid_q[k-1];
      addr_d[k]  = addr_q[k-1];
      tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
    end
  end

  // MDU countdown; a start while already busy is ignored.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.md_start && cnt_q == '0) begin
      cnt_d = bus.md_is_div ? CW'(MD_DIV_CYCLES) : CW'(MD_MUL_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      addr_q  <= '{default: '0};
      tnew_q  <= '{default: '0};
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      tnew_q  <= tnew_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, ALU-use, branch-use, nearest-match shadowing,
// $0 handling, unused operands, MDU busy/stall timing and mid-operation reset.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(5), .TW(3), .FW(2)) bus ();

  hazard_scoreboard #(
    .NUM_STAGES   (3),
    .REG_AW       (5),
    .TW           (3),
    .MD_MUL_CYCLES(5),
    .MD_DIV_CYCLES(10),
    .CW           (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] tu_rs,
                       input logic [2:0] tu_rt, input logic we, input logic [4:0] dest,
                       input logic [2:0] tnew, input logic md_use);
    bus.rs_D     = rs;
    bus.rt_D     = rt;
    bus.Tuse_rs  = tu_rs;
    bus.Tuse_rt  = tu_rt;
    bus.we_D     = we;
    bus.dest_D   = dest;
    bus.Tnew_D   = tnew;
    bus.md_use_D = md_use;
  endtask

  task automatic nop_d();
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 1'b0, 5'd0, 3'd0, 1'b0);
  endtask

  task automatic check_out(input string tag, input logic stall, input logic [1:0] frs,
                           input logic [1:0] frt, input logic busy);
    #3;
    checks++;
    assert (bus.stall_D === stall) else begin
      errors++;
      $error("FAIL %s stall_D: observed=%0b expected=%0b", tag, bus.stall_D, stall);
    end
    checks++;
    assert (bus.fwd_rs_D === frs) else begin
      errors++;
      $error("FAIL %s fwd_rs_D: observed=%0d expected=%0d", tag, bus.fwd_rs_D, frs);
    end
    checks++;
    assert (bus.fwd_rt_D === frt) else begin
      errors++;
      $error("FAIL %s fwd_rt_D: observed=%0d expected=%0d", tag, bus.fwd_rt_D, frt);
    end
    checks++;
    assert (bus.md_busy === busy) else begin
      errors++;
      $error("FAIL %s md_busy: observed=%0b expected=%0b", tag, bus.md_busy, busy);
    end
  endtask

  task automatic flush();
    nop_d();
    repeat (3) tick();
  endtask

  initial begin
    reset         = 1'b1;
    bus.md_start  = 1'b0;
    bus.md_is_div = 1'b0;
    nop_d();
    tick();
    tick();
    reset = 1'b0;
    check_out("reset", 1'b0, 2'd0, 2'd0, 1'b0);

    // lw $8 (Tnew 2), then add $9,$8,$1 (Tuse 1): one stall, lw reaches W with tnew 0
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 1'b1, 5'd8, 3'd2, 1'b0);
    check_out("lw_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(5'd8, 5'd1, 3'd1, 3'd1, 1'b1, 5'd9, 3'd1, 1'b0);
    check_out("lw_use_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    tick();
    check_out("lw_use_release", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    // lw now in stage 3 with tnew 0; a reader of $8 forwards from W
    set_d(5'd8, 5'd0, 3'd0, 3'd7, 1'b0, 5'd0, 3'd0, 1'b0);
    check_out("lw_fwd_w", 1'b0, 2'd3, 2'd0, 1'b0);
    flush();

    // ori $8 (Tnew 1): addu rt=$8 (Tuse 1) no stall; beq on $8 (Tuse 0) stalls once
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 1'b1, 5'd8, 3'd1, 1'b0);
    tick();
    set_d(5'd0, 5'd8, 3'd1, 3'd1, 1'b1, 5'd10, 3'd1, 1'b0);
    check_out("alu_use_rt", 1'b0, 2'd0, 2'd0, 1'b0);
    set_d(5'd8, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    check_out("beq_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    tick();
    check_out("beq_fwd_m", 1'b0, 2'd2, 2'd0, 1'b0);
    flush();

    // ori $8 then lui $8, both tnew 0: nearest (stage 1) wins
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 1'b1, 5'd8, 3'd0, 1'b0);
    tick();
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 1'b1, 5'd8, 3'd0, 1'b0);
    tick();
    set_d(5'd8, 5'd8, 3'd1, 3'd1, 1'b0, 5'd0, 3'd0, 1'b0);
    check_out("nearest_wins", 1'b0, 2'd1, 2'd1, 1'b0);
    // younger lw $8 in stage 1 shadows the ready older $8 in stage 2
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 1'b1, 5'd8, 3'd2, 1'b0);
    tick();
    set_d(5'd8, 5'd0, 3'd1, 3'd7, 1'b0, 5'd0, 3'd0, 1'b0);
    check_out("shadowed", 1'b1, 2'd0, 2'd0, 1'b0);
    flush();

    // Write to $0 is never tracked; reader of $0 never stalls/forwards
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 1'b1, 5'd0, 3'd2, 1'b0);
    tick();
    set_d(5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    check_out("dest_zero", 1'b0, 2'd0, 2'd0, 1'b0);
    flush();

    // Tuse all-ones: operand unused even if it matches an in-flight load
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 1'b1, 5'd8, 3'd2, 1'b0);
    tick();
    set_d(5'd8, 5'd8, 3'd7, 3'd7, 1'b0, 5'd0, 3'd0, 1'b0);
    check_out("tuse_unused", 1'b0, 2'd0, 2'd0, 1'b0);
    // Tnew all-ones is a real value: beats even Tuse 6
    flush();
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 1'b1, 5'd8, 3'd7, 1'b0);
    tick();
    set_d(5'd8, 5'd0, 3'd6, 3'd7, 1'b0, 5'd0, 3'd0, 1'b0);
    check_out("tnew_max", 1'b1, 2'd0, 2'd0, 1'b0);
    flush();
    flush();
    flush();

    // mult start with mfhi in D: stall 6 cycles, busy 5
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 1'b0, 5'd0, 3'd0, 1'b1);
    bus.md_start  = 1'b1;
    bus.md_is_div = 1'b0;
    check_out("mult_start", 1'b1, 2'd0, 2'd0, 1'b0);
    tick();
    bus.md_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_out($sformatf("mult_busy%0d", i), 1'b1, 2'd0, 2'd0, 1'b1);
      tick();
    end
    check_out("mult_done", 1'b0, 2'd0, 2'd0, 1'b0);

    // div: busy 10 cycles
    nop_d();
    bus.md_start  = 1'b1;
    bus.md_is_div = 1'b1;
    tick();
    bus.md_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_out($sformatf("div_busy%0d", i), 1'b0, 2'd0, 2'd0, 1'b1);
      tick();
    end
    check_out("div_done", 1'b0, 2'd0, 2'd0, 1'b0);

    // Second start while busy does not reload
    bus.md_start  = 1'b1;
    bus.md_is_div = 1'b0;
    tick();
    bus.md_start = 1'b0;
    tick();
    bus.md_start  = 1'b1;
    bus.md_is_div = 1'b1;
    tick();
    bus.md_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_out($sformatf("restart_busy%0d", i), 1'b0, 2'd0, 2'd0, 1'b1);
      tick();
    end
    check_out("restart_done", 1'b0, 2'd0, 2'd0, 1'b0);

    // Reset with cnt=3 and lw $8 in stage 1
    bus.md_start  = 1'b1;
    bus.md_is_div = 1'b0;
    tick();
    bus.md_start = 1'b0;
    tick();
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 1'b1, 5'd8, 3'd2, 1'b0);
    tick();
    set_d(5'd8, 5'd0, 3'd1, 3'd7, 1'b1, 5'd9, 3'd1, 1'b1);
    check_out("pre_reset", 1'b1, 2'd0, 2'd0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_out("post_reset", 1'b0, 2'd0, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
